// File: rtl/divider.sv
// Unsigned 16/8 restoring divider: dividend on INBUS at start, divisor on the next cycle,
// result {remainder, quotient} on OUTBUS with a one-cycle done pulse.
module divider (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic [15:0] INBUS,
    output logic [15:0] OUTBUS,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadDvs,
        StCheck,
        StIter,
        StFinish
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dividend_q, dividend_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  quo_q, quo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_pend_q, err_pend_d;
    logic [15:0] outbus_q, outbus_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [8:0]  rem_shift;
    logic [7:0]  quo_shift;

    assign rem_shift = {rem_q[7:0], quo_q[7]};
    assign quo_shift = {quo_q[6:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        outbus_d   = outbus_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dividend_d = INBUS;
                    busy_d     = 1'b1;
                    state_d    = StLoadDvs;
                end
            end
            StLoadDvs: begin
                divisor_d = INBUS[7:0];
                state_d   = StCheck;
            end
            StCheck: begin
                // Upper dividend byte >= divisor means the quotient cannot fit in 8 bits
                if (divisor_q == 8'h00 || dividend_q[15:8] >= divisor_q) begin
                    err_pend_d = 1'b1;
                    state_d    = StFinish;
                end else begin
                    err_pend_d = 1'b0;
                    rem_d      = {1'b0, dividend_q[15:8]};
                    quo_d      = dividend_q[7:0];
                    cnt_d      = 3'd0;
                    state_d    = StIter;
                end
            end
            StIter: begin
                if (rem_shift >= {1'b0, divisor_q}) begin
                    rem_d = rem_shift - {1'b0, divisor_q};
                    quo_d = quo_shift | 8'h01;
                end else begin
                    rem_d = rem_shift;
                    quo_d = quo_shift;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                outbus_d = err_pend_q ? 16'hFFFF : {rem_q[7:0], quo_q};
                done_d   = 1'b1;
                err_d    = err_pend_q;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            dividend_q <= 16'h0000;
            divisor_q  <= 8'h00;
            rem_q      <= 9'h000;
            quo_q      <= 8'h00;
            cnt_q      <= 3'd0;
            err_pend_q <= 1'b0;
            outbus_q   <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            outbus_q   <= outbus_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign OUTBUS = outbus_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: nominal, boundary, error, reset-abort and start-abuse cases.
module tb_divider;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic [15:0] INBUS;
    logic [15:0] OUTBUS;
    logic        done;
    logic        err;
    logic        busy;

    int total;
    int fails;

    divider dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .start  (start),
        .INBUS  (INBUS),
        .OUTBUS (OUTBUS),
        .done   (done),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives E0 and E1; returns just after E1.
    task automatic launch(input logic [15:0] dvd, input logic [15:0] dvs_bus);
        start = 1'b1;
        INBUS = dvd;
        step();
        chk("busy_after_e0", {31'b0, busy}, 32'd1);
        start = 1'b0;
        INBUS = dvs_bus;
        step();
        INBUS = 16'h5A5A;
    endtask

    // From just after E1, wait (bounded) for done; check edge index and result.
    task automatic finish_op(input string tag, input int exp_edge, input logic [15:0] exp_out,
                             input logic exp_err);
        int k;
        for (k = 2; k <= 20; k++) begin
            step();
            if (done) break;
        end
        chk({tag, "_done_edge"}, k, exp_edge);
        chk({tag, "_outbus"}, {16'b0, OUTBUS}, {16'b0, exp_out});
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        step();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_err_clear"}, {31'b0, err}, 32'd0);
        chk({tag, "_hold"}, {16'b0, OUTBUS}, {16'b0, exp_out});
    endtask

    initial begin
        int ndone;
        total = 0;
        fails = 0;
        rst_b = 1'b0;
        start = 1'b0;
        INBUS = 16'h0000;
        step();
        step();
        chk("rst_outbus", {16'b0, OUTBUS}, 32'h0);
        chk("rst_flags", {29'b0, done, err, busy}, 32'h0);
        rst_b = 1'b1;
        step();

        launch(16'h1234, 16'hFF56);
        finish_op("nominal", 11, 16'h1036, 1'b0);

        launch(16'hFEFF, 16'h00FF);
        finish_op("max", 11, 16'hFEFF, 1'b0);

        launch(16'h00FF, 16'hAB00);
        finish_op("divzero", 3, 16'hFFFF, 1'b1);

        launch(16'h4A00, 16'h004A);
        finish_op("overflow", 3, 16'hFFFF, 1'b1);

        // Reset asynchronously between E5 and E6.
        launch(16'h1234, 16'h0056);
        for (int i = 2; i <= 5; i++) step();
        #2 rst_b = 1'b0;
        #2;
        chk("abort_outbus", {16'b0, OUTBUS}, 32'h0);
        chk("abort_flags", {29'b0, done, err, busy}, 32'h0);
        #3 rst_b = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        launch(16'h0064, 16'h0007);
        finish_op("after_reset", 11, 16'h020E, 1'b0);

        // Start abuse: random start/INBUS during E2..E10, then start held for back-to-back.
        launch(16'h1234, 16'h0056);
        ndone = 0;
        for (int i = 2; i <= 10; i++) begin
            start = i[0];
            INBUS = 16'($urandom);
            step();
            if (done) ndone++;
        end
        chk("abuse_no_early_done", ndone, 0);
        start = 1'b1;
        INBUS = 16'h1234;
        step();
        chk("abuse_done_e11", {31'b0, done}, 32'd1);
        chk("abuse_outbus", {16'b0, OUTBUS}, 32'h1036);
        chk("abuse_err", {31'b0, err}, 32'd0);
        step();
        chk("abuse_restart_e12_busy", {31'b0, busy}, 32'd1);
        chk("abuse_restart_e12_done", {31'b0, done}, 32'd0);
        start = 1'b0;
        INBUS = 16'h0056;
        step();
        INBUS = 16'h0000;
        finish_op("abuse_second", 11, 16'h1036, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
